serial_cmd_master: RTL

- Host-side peer of the serial UART byte interface: consumes received bytes (strobe plus data), decodes a fixed binary command protocol, executes 16-bit register reads/writes on the internal monitor bus, and returns response bytes through the UART transmit handshake.
- Sits between the UART and the monitor register bus, giving an external PC register access over RS-232.

---
 rtl/serial_cmd_master_if.sv | 26 ++
 rtl/serial_cmd_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_master_if.sv
// Bundle of the UART byte handshake and the monitor register bus.
// The master modport is the command engine's view; the slave modport is
// the view of whatever sits across from it (UART plus register file).
interface serial_cmd_master_if;
   logic [7:0]  as_data_i;
   logic        as_dstrb_i;
   logic [7:0]  as_data_o;
   logic        as_dstrb_o;
   logic        as_busy_i;
   logic [15:0] bus_addr;
   logic [15:0] bus_data_o;
   logic [15:0] bus_data_i;
   logic        bus_we;
   logic        bus_stb;
   logic        bus_ack;

   modport master (
      input  as_data_i, as_dstrb_i, as_busy_i, bus_data_i, bus_ack,
      output as_data_o, as_dstrb_o, bus_addr, bus_data_o, bus_we, bus_stb
   );

   modport slave (
      output as_data_i, as_dstrb_i, as_busy_i, bus_data_i, bus_ack,
      input  as_data_o, as_dstrb_o, bus_addr, bus_data_o, bus_we, bus_stb
   );
endinterface

// File: rtl/serial_cmd_master.sv
// Serial command master: decodes binary read/write frames arriving from
// the UART, runs one 16-bit access on the monitor bus and sends back the
// response bytes (ACK 0x06, NAK 0x15 or the two read-data bytes).
module serial_cmd_master #(
   parameter int unsigned BYTE_TIMEOUT = 400000,
   parameter int unsigned BUS_TIMEOUT  = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   serial_cmd_master_if.master  sif,
   output logic                 cmd_active,
   output logic [7:0]           err_count
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ADDR_HI = 3'd1;
   localparam logic [2:0] ADDR_LO = 3'd2;
   localparam logic [2:0] DATA_HI = 3'd3;
   localparam logic [2:0] DATA_LO = 3'd4;
   localparam logic [2:0] BUS     = 3'd5;
   localparam logic [2:0] TX_WAIT = 3'd6;
   localparam logic [2:0] TX_GAP  = 3'd7;

   localparam int unsigned BT_W = $clog2(BYTE_TIMEOUT + 1);
   localparam int unsigned ST_W = $clog2(BUS_TIMEOUT + 1);
   localparam logic [BT_W-1:0] BYTE_LAST = BT_W'(BYTE_TIMEOUT - 1);
   localparam logic [ST_W-1:0] BUS_LAST  = ST_W'(BUS_TIMEOUT - 1);

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;

   logic [2:0]      state_q, state_d;
   logic            write_q, write_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     wdata_q, wdata_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic [7:0]      txData_q, txData_d;
   logic            txStrb_q, txStrb_d;
   logic [15:0]     txQueue_q, txQueue_d;
   logic [1:0]      txLeft_q, txLeft_d;
   logic [BT_W-1:0] byteTimer_q, byteTimer_d;
   logic [ST_W-1:0] busTimer_q, busTimer_d;
   logic [7:0]      err_q, err_d;

   // Next-state logic: frame decoding, bus cycle supervision and response
   // sequencing all live in one FSM, the response bytes wait in a small
   // two-byte shift queue that is sent MSB byte first.
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      stb_d       = stb_q;
      we_d        = we_q;
      txData_d    = txData_q;
      txStrb_d    = 1'b0;
      txQueue_d   = txQueue_q;
      txLeft_d    = txLeft_q;
      byteTimer_d = byteTimer_q;
      busTimer_d  = busTimer_q;
      err_d       = err_q;

      case (state_q)
         IDLE: begin
            if (sif.as_dstrb_i) begin
               byteTimer_d = '0;
               if (sif.as_data_i == OP_WRITE) begin
                  write_d = 1'b1;
                  state_d = ADDR_HI;
               end else if (sif.as_data_i == OP_READ) begin
                  write_d = 1'b0;
                  state_d = ADDR_HI;
               end else begin
                  txQueue_d = {RSP_NAK, 8'h00};
                  txLeft_d  = 2'd1;
                  if (err_q != 8'hFF) err_d = err_q + 8'd1;
                  state_d   = TX_WAIT;
               end
            end
         end

         ADDR_HI, ADDR_LO, DATA_HI, DATA_LO: begin
            if (sif.as_dstrb_i) begin
               byteTimer_d = '0;
               case (state_q)
                  ADDR_HI: begin
                     addr_d[15:8] = sif.as_data_i;
                     state_d      = ADDR_LO;
                  end
                  ADDR_LO: begin
                     addr_d[7:0] = sif.as_data_i;
                     state_d     = write_q ? DATA_HI : BUS;
                  end
                  DATA_HI: begin
                     wdata_d[15:8] = sif.as_data_i;
                     state_d       = DATA_LO;
                  end
                  default: begin
                     wdata_d[7:0] = sif.as_data_i;
                     state_d      = BUS;
                  end
               endcase
               if (state_d == BUS) begin
                  stb_d      = 1'b1;
                  we_d       = write_q;
                  busTimer_d = '0;
               end
            end else if (byteTimer_q == BYTE_LAST) begin
               state_d = IDLE;
            end else begin
               byteTimer_d = byteTimer_q + BT_W'(1);
            end
         end

         BUS: begin
            if (sif.bus_ack) begin
               stb_d   = 1'b0;
               we_d    = 1'b0;
               state_d = TX_WAIT;
               if (write_q) begin
                  txQueue_d = {RSP_ACK, 8'h00};
                  txLeft_d  = 2'd1;
               end else begin
                  txQueue_d = sif.bus_data_i;
                  txLeft_d  = 2'd2;
               end
            end else if (busTimer_q == BUS_LAST) begin
               stb_d     = 1'b0;
               we_d      = 1'b0;
               txQueue_d = {RSP_NAK, 8'h00};
               txLeft_d  = 2'd1;
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
               state_d   = TX_WAIT;
            end else begin
               busTimer_d = busTimer_q + ST_W'(1);
            end
         end

         TX_WAIT: begin
            if (!sif.as_busy_i) begin
               txStrb_d  = 1'b1;
               txData_d  = txQueue_q[15:8];
               txQueue_d = {txQueue_q[7:0], 8'h00};
               txLeft_d  = txLeft_q - 2'd1;
               state_d   = TX_GAP;
            end
         end

         default: begin
            state_d = (txLeft_q != 2'd0) ? TX_WAIT : IDLE;
         end
      endcase
   end

   // State registers; the asynchronous reset aborts any frame or bus cycle
   // in flight and drops the bus strobe without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         txData_q    <= '0;
         txStrb_q    <= 1'b0;
         txQueue_q   <= '0;
         txLeft_q    <= '0;
         byteTimer_q <= '0;
         busTimer_q  <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         txData_q    <= txData_d;
         txStrb_q    <= txStrb_d;
         txQueue_q   <= txQueue_d;
         txLeft_q    <= txLeft_d;
         byteTimer_q <= byteTimer_d;
         busTimer_q  <= busTimer_d;
         err_q       <= err_d;
      end
   end

   assign sif.as_data_o  = txData_q;
   assign sif.as_dstrb_o = txStrb_q;
   assign sif.bus_addr   = addr_q;
   assign sif.bus_data_o = wdata_q;
   assign sif.bus_we     = we_q;
   assign sif.bus_stb    = stb_q;
   assign cmd_active     = (state_q != IDLE);
   assign err_count      = err_q;
endmodule
